mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the MIPS core. It sits beside the ALU, downstream of the GPR read ports. It takes the two register operands (rs, rt) and a decoded op from `ctrl`. It computes into a private HI/LO pair over a fixed multi-cycle latency and exposes HI/LO to the write-back mux. The core stalls its fetch/PC update while `Busy` is high or an MDU op is being issued against a busy unit.

## Interface
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for mult/madd/msub family; must be ≥ 1.
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for div/divu; must be ≥ 1.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  issue strobe for the op on `MDOp`, sampled on the rising edge.
- `MDOp`  in  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu; 10–15 reserved.
- `A`  in  32  rs operand (GPR RData1).
- `B`  in  32  rt operand (GPR RData2).
- `Busy`  out  1  registered; high while an arithmetic op is in flight.
- `HI`  out  32  registered HI.
- `LO`  out  32  registered LO.

## Operation
- Two states: IDLE, RUN. A down-counter (width covers max(MULT_CYCLES, DIV_CYCLES)) and a 64-bit pending result register accompany them.
- IDLE, `Start`=1, arithmetic op (0–3, 6–9):
  - compute the 64-bit result from A, B, HI, LO as sampled at that edge and store it in pending;
  - load the counter with the op's cycle count;
  - go to RUN and set `Busy`=1.
- IDLE, `Start`=1, mthi: HI←A at that edge. mtlo: LO←A at that edge. No `Busy`.
- `Start`=1 with a reserved op: no state change.
- RUN: the counter decrements each edge. On the edge where it would reach 0:
  - {HI,LO}←pending;
  - `Busy`←0;
  - go to IDLE.
- `Start` while in RUN (including mthi/mtlo) is ignored. The core must hold the instruction until `Busy`=0.
- Arithmetic:
  - mult: signed 32×32→64.
  - multu: unsigned 32×32→64.
  - {HI,LO} = product.
  - madd/maddu: {HI,LO}+product, mod 2^64.
  - msub/msubu: {HI,LO}−product, mod 2^64.
  - div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Boundary results:
  - Divide by zero (B=0): LO=32'hFFFFFFFF, HI=A, for both signed and unsigned.
  - Signed overflow 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- `HI`/`LO` hold their value during RUN. Reads (mfhi/mflo) issued while `Busy` get the old values; the core must stall them.

## Timing
- Reset value: `Busy`=0, `HI`=0, `LO`=0, state IDLE, counter 0, pending 0.
- Reset asserted mid-RUN aborts the operation immediately. The pending result is discarded; HI/LO stay 0.
- `Start` accepted at edge k for an N-cycle op:
  - `Busy` is high from after edge k through edge k+N;
  - HI/LO take the result at edge k+N, the same edge that `Busy` falls.
- Back-to-back issue: a `Start` sampled at edge k+N is ignored, because `Busy` is still 1 during the cycle before it. The earliest accepted next `Start` is edge k+N+1.
- mthi/mtlo latency: 1 edge.
- There is no combinational path from inputs to outputs.

## Configuration
- `MDU_MADD_EN`:
  - Defined: ops 6–9 (madd, maddu, msub, msubu) are implemented as described above.
  - Undefined: ops 6–9 are treated as reserved (`Start` is ignored, no `Busy`, HI/LO unchanged). The accumulate adder is not synthesized.

## Test plan
- Reset, then mult with A=32'hFFFFFFFE (−2), B=3 → `Busy` high for 5 cycles; HI=32'hFFFFFFFF, LO=32'hFFFFFFFA at edge k+5. Repeat with multu → HI=2, LO=32'hFFFFFFFA.
- div A=−7 (32'hFFFFFFF9), B=2 → after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu A=7, B=0 → LO=32'hFFFFFFFF, HI=7.
- mtlo A=5, then a `Start` with mult A=2, B=3 issued while `Busy` from an earlier div → the mult is ignored; final HI/LO equal the div result only.
- Reset pulsed 3 cycles into a div → `Busy`=0, HI=LO=0 immediately; no late write-back appears after reset is released.
- With `MDU_MADD_EN`: mthi 0, mtlo 32'hFFFFFFFF, then maddu A=1, B=1 → HI=1, LO=0. Without the macro: the same sequence leaves HI=0, LO=32'hFFFFFFFF and `Busy` never rises.
- Signed 32'h80000000 div 32'hFFFFFFFF → LO=32'h80000000, HI=0.

Source files
------------

// File: rtl/mdu.sv
// ============================================================================
//  Module   : mdu
//  Brief    : MIPS multiply/divide unit with a private HI/LO pair. Arithmetic
//             ops run for a fixed number of cycles with Busy high and commit
//             their result to HI/LO on the final edge. mthi/mtlo write in one
//             edge. Optional accumulate ops (madd/maddu/msub/msubu) are
//             enabled by defining the macro MDU_MADD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [63:0]      pend_q,  pend_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic             busy_q,  busy_d;

    logic             w_is_div;
    logic             w_is_arith;
    logic [CNT_W-1:0] w_op_cycles;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_a_mag, w_b_mag;
    logic [31:0]      w_dvd, w_dvs, w_dvs_safe;
    logic [31:0]      w_quot_mag, w_rem_mag;
    logic [31:0]      w_quot, w_rem;
    logic             w_neg_q, w_neg_r;
    logic [63:0]      w_div_res;
    logic [63:0]      w_result;

    // Op classification and latency selection for the issuing op
    assign w_is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
    assign w_is_arith = (MDOp <= OP_DIVU) || ((MDOp >= OP_MADD) && (MDOp <= OP_MSUBU));
`else
    assign w_is_arith = (MDOp <= OP_DIVU);
`endif
    assign w_op_cycles = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Products: sign-extend to 64 bits so the low 64 bits of the product are exact
    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Single unsigned divider; signed division works on magnitudes and
    // restores signs afterwards (quotient toward zero, remainder follows
    // the dividend). 0x80000000 / -1 falls out naturally as 0x80000000, r=0.
    assign w_a_mag    = A[31] ? (~A + 32'd1) : A;
    assign w_b_mag    = B[31] ? (~B + 32'd1) : B;
    assign w_dvd      = (MDOp == OP_DIV) ? w_a_mag : A;
    assign w_dvs      = (MDOp == OP_DIV) ? w_b_mag : B;
    assign w_dvs_safe = (B == 32'd0) ? 32'd1 : w_dvs;
    assign w_quot_mag = w_dvd / w_dvs_safe;
    assign w_rem_mag  = w_dvd % w_dvs_safe;
    assign w_neg_q    = (MDOp == OP_DIV) && (A[31] ^ B[31]);
    assign w_neg_r    = (MDOp == OP_DIV) && A[31];
    assign w_quot     = w_neg_q ? (~w_quot_mag + 32'd1) : w_quot_mag;
    assign w_rem      = w_neg_r ? (~w_rem_mag + 32'd1) : w_rem_mag;
    assign w_div_res  = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {w_rem, w_quot};

    // 64-bit result of the issuing op, evaluated against the current HI/LO
    always_comb begin
        w_result = 64'd0;
        case (MDOp)
            OP_MULT:          w_result = w_prod_s;
            OP_MULTU:         w_result = w_prod_u;
            OP_DIV, OP_DIVU:  w_result = w_div_res;
`ifdef MDU_MADD_EN
            OP_MADD:          w_result = {hi_q, lo_q} + w_prod_s;
            OP_MADDU:         w_result = {hi_q, lo_q} + w_prod_u;
            OP_MSUB:          w_result = {hi_q, lo_q} - w_prod_s;
            OP_MSUBU:         w_result = {hi_q, lo_q} - w_prod_u;
`endif
            default:          w_result = 64'd0;
        endcase
    end

    // Next-state logic: accept ops in IDLE, count down and commit in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (w_is_arith) begin
                        pend_d  = w_result;
                        cnt_d   = w_op_cycles;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end else if (MDOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                // Start is ignored here; the core holds the instruction
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any in-flight op and clears HI/LO
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
// ============================================================================
//  Module   : tb_mdu
//  Brief    : Directed self-checking bench for mdu (HI/LO arithmetic, busy
//             timing, issue blocking, mid-op reset, optional accumulate ops).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_chk  = 0;
    int n_fail = 0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one issue strobe, sampled at the next rising edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got Busy=%b HI=%h LO=%h, want 0/0/0", Busy, HI, LO);
        end
    endtask

    task automatic test_mult();
        logic [3:0]  op  [0:2];
        logic [31:0] va  [0:2];
        logic [31:0] vb  [0:2];
        logic [63:0] exp [0:2];
        logic [63:0] old;
        op[0] = 4'd0; va[0] = 32'hFFFF_FFFE; vb[0] = 32'd3;           exp[0] = 64'hFFFF_FFFF_FFFF_FFFA;
        op[1] = 4'd1; va[1] = 32'hFFFF_FFFE; vb[1] = 32'd3;           exp[1] = 64'h0000_0002_FFFF_FFFA;
        op[2] = 4'd0; va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000;   exp[2] = 64'h4000_0000_0000_0000;
        for (int v = 0; v < 3; v++) begin
            old = {HI, LO};
            issue(op[v], va[v], vb[v]);
            n_chk++;
            if (Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL mult%0d_busy_rise: got Busy=%b, want 1", v, Busy);
            end
            for (int c = 1; c <= MC; c++) begin
                @(posedge Clk); #1;
                n_chk++;
                if (c < MC) begin
                    if (Busy !== 1'b1 || {HI, LO} !== old) begin
                        n_fail++;
                        $display("FAIL mult%0d_hold_c%0d: got Busy=%b HILO=%h, want 1 %h", v, c, Busy, {HI, LO}, old);
                    end
                end else if (Busy !== 1'b0 || {HI, LO} !== exp[v]) begin
                    n_fail++;
                    $display("FAIL mult%0d_result: got Busy=%b HILO=%h, want 0 %h", v, Busy, {HI, LO}, exp[v]);
                end
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]  op  [0:5];
        logic [31:0] va  [0:5];
        logic [31:0] vb  [0:5];
        logic [63:0] exp [0:5];
        logic [63:0] old;
        op[0] = 4'd2; va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;         exp[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        op[1] = 4'd2; va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE; exp[1] = {32'd1,         32'hFFFF_FFFD};
        op[2] = 4'd3; va[2] = 32'hFFFF_FFF9; vb[2] = 32'd2;         exp[2] = {32'd1,         32'h7FFF_FFFC};
        op[3] = 4'd2; va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; exp[3] = {32'd0,         32'h8000_0000};
        op[4] = 4'd2; va[4] = 32'hFFFF_FFF9; vb[4] = 32'd0;         exp[4] = {32'hFFFF_FFF9, 32'hFFFF_FFFF};
        op[5] = 4'd3; va[5] = 32'd7;         vb[5] = 32'd0;         exp[5] = {32'd7,         32'hFFFF_FFFF};
        for (int v = 0; v < 6; v++) begin
            old = {HI, LO};
            issue(op[v], va[v], vb[v]);
            for (int c = 1; c <= DC; c++) begin
                @(posedge Clk); #1;
                if (c == DC) begin
                    n_chk++;
                    if (Busy !== 1'b0 || {HI, LO} !== exp[v]) begin
                        n_fail++;
                        $display("FAIL div%0d_result: got Busy=%b HILO=%h, want 0 %h", v, Busy, {HI, LO}, exp[v]);
                    end
                end else if (c == DC - 1) begin
                    n_chk++;
                    if (Busy !== 1'b1 || {HI, LO} !== old) begin
                        n_fail++;
                        $display("FAIL div%0d_hold: got Busy=%b HILO=%h, want 1 %h", v, Busy, {HI, LO}, old);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        // HI=7, LO=FFFFFFFF from the previous test; mtlo makes LO=5
        issue(4'd5, 32'd5, 32'd0);
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd7 || LO !== 32'd5) begin
            n_fail++;
            $display("FAIL mtlo: got Busy=%b HI=%h LO=%h, want 0 7 5", Busy, HI, LO);
        end
        issue(4'd2, 32'd100, 32'd7);        // edge k: 100/7 -> q=14 r=2
        repeat (2) @(posedge Clk);          // edges k+1, k+2
        #1 issue(4'd0, 32'd2, 32'd3);       // mult sampled at k+3 while busy
        issue(4'd4, 32'hDEAD_BEEF, 32'd0);  // mthi sampled at k+4 while busy
        n_chk++;
        if (Busy !== 1'b1 || HI !== 32'd7 || LO !== 32'd5) begin
            n_fail++;
            $display("FAIL busy_ignore: got Busy=%b HI=%h LO=%h, want 1 7 5", Busy, HI, LO);
        end
        repeat (DC - 5) @(posedge Clk);     // through edge k+N-1
        #1;
        // Hold a mult strobe across edge k+N (ignored) and k+N+1 (accepted)
        Start = 1'b1; MDOp = 4'd0; A = 32'd2; B = 32'd3;
        @(posedge Clk); #1;
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_commit: got Busy=%b HI=%h LO=%h, want 0 2 e", Busy, HI, LO);
        end
        @(posedge Clk); #1;
        Start = 1'b0;
        n_chk++;
        if (Busy !== 1'b1 || HI !== 32'd2 || LO !== 32'd14) begin
            n_fail++;
            $display("FAIL b2b_accept: got Busy=%b HI=%h LO=%h, want 1 2 e", Busy, HI, LO);
        end
        repeat (MC) @(posedge Clk);
        #1;
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_mult: got Busy=%b HI=%h LO=%h, want 0 0 6", Busy, HI, LO);
        end
    endtask

    task automatic test_reset_mid_run();
        issue(4'd2, 32'd9, 32'd2);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_abort: got Busy=%b HI=%h LO=%h, want 0 0 0", Busy, HI, LO);
        end
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (DC + 2) @(posedge Clk);
        #1;
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_no_late_wb: got Busy=%b HI=%h LO=%h, want 0 0 0", Busy, HI, LO);
        end
    endtask

    task automatic test_reserved();
        issue(4'd4, 32'h1234_5678, 32'd0);
        issue(4'd12, 32'd3, 32'd3);
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reserved_op: got Busy=%b HI=%h LO=%h, want 0 12345678 0", Busy, HI, LO);
        end
    endtask

    task automatic test_madd();
        int busy_seen;
        issue(4'd4, 32'd0, 32'd0);
        issue(4'd5, 32'hFFFF_FFFF, 32'd0);
        issue(4'd7, 32'd1, 32'd1);          // maddu 1*1
        busy_seen = (Busy === 1'b1) ? 1 : 0;
        for (int c = 1; c < MC; c++) begin
            @(posedge Clk); #1;
            if (Busy === 1'b1) busy_seen++;
        end
        @(posedge Clk); #1;
`ifdef MDU_MADD_EN
        n_chk++;
        if (busy_seen != MC || Busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL maddu: got busy_cycles=%0d HI=%h LO=%h, want %0d 1 0", busy_seen, HI, LO, MC);
        end
        // msub (-1)*1 from {1,0}: 0x1_00000000 + 1
        issue(4'd8, 32'hFFFF_FFFF, 32'd1);
        repeat (MC) @(posedge Clk);
        #1;
        n_chk++;
        if (Busy !== 1'b0 || HI !== 32'd1 || LO !== 32'd1) begin
            n_fail++;
            $display("FAIL msub: got Busy=%b HI=%h LO=%h, want 0 1 1", Busy, HI, LO);
        end
`else
        n_chk++;
        if (busy_seen != 0 || Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL maddu_disabled: got busy_cycles=%0d HI=%h LO=%h, want 0 0 ffffffff", busy_seen, HI, LO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_mid_run();
        test_reserved();
        test_madd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
